// File: rtl/quad_decoder_pkg.sv
// +----------------------------------------------------------------------+
// | qdec_pkg: shared phase/state types and the quadrature up-step table. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package qdec_pkg;

  localparam int SYNC_STAGES = 2;

  typedef logic [1:0] phase_t;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // Phase {A,B} one step forward in the 00->10->11->01->00 cycle.
  function automatic phase_t next_up(input phase_t p);
    case (p)
      2'b00:   next_up = 2'b10;
      2'b10:   next_up = 2'b11;
      2'b11:   next_up = 2'b01;
      default: next_up = 2'b00;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_decoder_input.sv
// +----------------------------------------------------------------------+
// | qdec_input: one encoder channel, 2-flop synchronizer plus optional   |
// | glitch filter (QUAD_DECODER_FILTER_EN).                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module qdec_input
  import qdec_pkg::*;
`ifdef QUAD_DECODER_FILTER_EN
#(
  parameter int FILT_CYCLES = 3
)
`endif
(
  input  logic clk50m,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

`ifdef QUAD_DECODER_FILTER_EN
  localparam int CNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The count restarts whenever the input agrees with the filtered value.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == CNT_W'(FILT_CYCLES - 1)) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

`default_nettype wire

// File: rtl/quad_decoder.sv
// +----------------------------------------------------------------------+
// | quad_decoder: x4 quadrature decoder with modulo position counter and |
// | illegal-transition flag. Optional filter: QUAD_DECODER_FILTER_EN.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module quad_decoder
  import qdec_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FILT_CYCLES = 3
)
(
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             down,
  output logic             err,
  output logic             err_sticky
);

`ifdef QUAD_DECODER_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  localparam int INIT_LEN = SYNC_STAGES + (FILT_EN ? FILT_CYCLES : 0);
  localparam int ICNT_W   = $clog2(INIT_LEN + 1);

  logic a_s;
  logic b_s;

`ifdef QUAD_DECODER_FILTER_EN
  qdec_input #(.FILT_CYCLES(FILT_CYCLES)) u_in_a (.clk50m(clk50m), .rst_n(rst_n), .din(a_in), .dout(a_s));
  qdec_input #(.FILT_CYCLES(FILT_CYCLES)) u_in_b (.clk50m(clk50m), .rst_n(rst_n), .din(b_in), .dout(b_s));
`else
  qdec_input u_in_a (.clk50m(clk50m), .rst_n(rst_n), .din(a_in), .dout(a_s));
  qdec_input u_in_b (.clk50m(clk50m), .rst_n(rst_n), .din(b_in), .dout(b_s));
`endif

  phase_t            phase;
  state_t            state_q,  state_d;
  logic [ICNT_W-1:0] icnt_q,   icnt_d;
  phase_t            ref_q,    ref_d;
  logic [WIDTH-1:0]  pos_q,    pos_d;
  logic              step_q,   step_d;
  logic              down_q,   down_d;
  logic              err_q,    err_d;
  logic              sticky_q, sticky_d;

  always_comb begin
    phase    = {a_s, b_s};
    state_d  = state_q;
    icnt_d   = icnt_q;
    ref_d    = ref_q;
    pos_d    = pos_q;
    step_d   = 1'b0;
    down_d   = down_q;
    err_d    = 1'b0;
    sticky_d = sticky_q;

    case (state_q)
      // Wait until the input pipeline carries real samples, not reset zeros.
      INIT: begin
        if (icnt_q == ICNT_W'(INIT_LEN)) begin
          ref_d   = phase;
          state_d = TRACK;
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end
      TRACK: begin
        if (phase != ref_q) begin
          ref_d = phase;
          if (phase == next_up(ref_q)) begin
            step_d = 1'b1;
            down_d = 1'b0;
            pos_d  = pos_q + 1'b1;
          end else if (ref_q == next_up(phase)) begin
            step_d = 1'b1;
            down_d = 1'b1;
            pos_d  = pos_q - 1'b1;
          end else begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase

    if (clr) begin
      pos_d    = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state_q  <= INIT;
      icnt_q   <= '0;
      ref_q    <= '0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      down_q   <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      icnt_q   <= icnt_d;
      ref_q    <= ref_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      down_q   <= down_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign pos        = pos_q;
  assign step       = step_q;
  assign down       = down_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule

`default_nettype wire

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, which sets the position counter width in bits.
REQ-002 The module SHALL have parameter FILT_CYCLES, default 3, which sets the glitch-filter stability length in clocks; it is used only when the filter is compiled in.
REQ-003 The module SHALL have port clk50m  input  1  system clock; every register updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The module SHALL have port a_in  input  1  encoder channel A, asynchronous to clk50m.
REQ-006 The module SHALL have port b_in  input  1  encoder channel B, asynchronous to clk50m.
REQ-007 The module SHALL have port clr  input  1  synchronous clear of pos and err_sticky.
REQ-008 The module SHALL have port pos  output  WIDTH  signed-agnostic position count.
REQ-009 The module SHALL have port step  output  1  one-clock pulse on each accepted quadrature edge.
REQ-010 The module SHALL have port down  output  1  direction of the last accepted step; 1 = decrement.
REQ-011 The module SHALL have port err  output  1  one-clock pulse on an illegal transition (both channels changed).
REQ-012 The module SHALL have port err_sticky  output  1  latched err; cleared only by reset or clr.

Function
REQ-013 The block SHALL pass a_in and b_in through 2-flop synchronizers before any other logic uses them.
REQ-014 The phase SHALL be defined as {A,B}; the sequence 00->10->11->01->00 SHALL be decoded as up (pos+1, down=0), and the reverse sequence as down (pos-1, down=1).
REQ-015 Decoding SHALL be x4: every legal single-bit phase change produces exactly one step pulse.
REQ-016 A phase equal to the previous phase SHALL produce no step, no err, and no pos change.
REQ-017 A phase change in which both bits flip SHALL assert err for one clock, set err_sticky, leave pos and down unchanged, and make the new phase the reference phase.
REQ-018 pos arithmetic SHALL be modulo 2^WIDTH: all-ones +1 -> 0, and 0 -1 -> all-ones, with no saturation and no flag.
REQ-019 Latency without the filter SHALL be as follows: a level change sampled at rising edge k produces the step, down and pos update registered at edge k+2.
REQ-020 clr SHALL have priority over a step in the same cycle: pos <= 0, with step/down still reported for that edge, and the reference phase still updated so that no spurious step follows.
REQ-021 The control FSM SHALL have 2 states, INIT and TRACK.
REQ-022 In INIT, the FSM SHALL wait until the synchronizer (and the filter, if present) holds valid data, then load the reference phase without decoding and go to TRACK.
REQ-023 In TRACK, the FSM SHALL decode every cycle and SHALL leave TRACK only on reset.
REQ-024 INIT SHALL last 2 clocks without the filter and 2+FILT_CYCLES clocks with it.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL set pos=0, step=0, down=0, err=0, err_sticky=0, clear the synchronizer and filter registers, and enter INIT.
REQ-026 A reset asserted mid-motion SHALL discard the reference phase, so that no step or err results from the phase at reset release.

Configuration
REQ-027 The macro QUAD_DECODER_FILTER_EN SHALL control the input glitch filter.
REQ-028 When QUAD_DECODER_FILTER_EN is defined, each synchronized channel SHALL be accepted only after it has differed from its filtered value for FILT_CYCLES consecutive clocks, which adds FILT_CYCLES clocks of latency; shorter pulses SHALL be ignored.
REQ-029 When QUAD_DECODER_FILTER_EN is not defined, the synchronizer output SHALL feed the decoder directly, and FILT_CYCLES SHALL be unused.

Structure
REQ-030 Package qdec_pkg SHALL hold the phase_t typedef (2-bit), the state_t enum (INIT, TRACK), and the constant SYNC_STAGES = 2.
REQ-031 Sub-module qdec_input SHALL contain one channel's synchronizer plus the optional filter, and SHALL be instantiated twice.

Verification
REQ-032 The bench SHALL cover this scenario: release reset with a_in=b_in=1 and hold -> no step and no err; pos=0 after INIT.
REQ-033 The bench SHALL cover this scenario: drive 100 up edges (WIDTH=6) from pos=0, each held 4 clocks -> 100 step pulses, down=0, pos=36 (100 mod 64).
REQ-034 The bench SHALL cover this scenario: then drive 200 down edges -> down=1, pos=(36-200) mod 64 = 28; wrap-around through 0 is checked.
REQ-035 The bench SHALL cover this scenario: flip a_in and b_in in the same clock -> err for exactly 1 clock, err_sticky=1, pos unchanged; then clr -> pos=0 and err_sticky=0.
REQ-036 The bench SHALL cover this scenario: assert clr on the same clock as an up step -> pos=0 (not 1) and no extra step afterward.
REQ-037 The bench SHALL cover this scenario: with QUAD_DECODER_FILTER_EN and FILT_CYCLES=3, apply a 2-clock glitch on a_in -> no step; a 3-clock-stable change -> one step, 3 clocks later than the unfiltered build.
